voice_allocator: RTL

Polyphonic voice allocator for the synthesiser. Takes debounced key levels from the board and assigns each newly pressed key to one of a fixed pool of oscillator voices. It drives per-voice enable, key index and phase-restart outputs into the oscillator bank, whose outputs the signal adder sums into the total output signal. Runs on the 1 MHz system clock.

---
 rtl/voice_if.sv | 25 ++
 rtl/voice_allocator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/voice_if.sv
// Key-level input and per-voice control outputs between the key board and the
// voice allocator; master drives keys, slave is the allocator.
interface voice_if #(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 3
);
  logic [NUM_KEYS-1:0]           keys;
  logic [NUM_VOICES-1:0]         voice_active;
  logic [NUM_VOICES*KEY_W-1:0]   voice_key;
  logic [NUM_VOICES-1:0]         voice_start;
  logic                          steal;
  logic                          drop;
  logic [$clog2(NUM_VOICES):0]   active_count;

  modport master (
    output keys,
    input  voice_active, voice_key, voice_start, steal, drop, active_count
  );

  modport slave (
    input  keys,
    output voice_active, voice_key, voice_start, steal, drop, active_count
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns newly pressed keys to a fixed voice pool.
// Define VOICE_STEAL_EN to let a press take the oldest voice when all are busy.
module voice_allocator #(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 3,
  parameter int AGE_W      = 2
) (
  input  logic   clk,
  input  logic   rst,
  voice_if.slave bus
);
  localparam int VID_W = $clog2(NUM_VOICES);
  localparam int CNT_W = VID_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_KEYS-1:0]   keys_q, pending, press, pending_nx;
  logic                  armed;
  logic [NUM_VOICES-1:0] active, start, rel, active_nx, start_nx;
  logic [KEY_W-1:0]      vkey [NUM_VOICES];
  logic [AGE_W-1:0]      age  [NUM_VOICES];
  logic                  steal_r, drop_r, steal_nx, drop_nx;
  logic [CNT_W-1:0]      count, count_nx;
  logic                  have_cand, have_free, alloc, stall;
  logic [KEY_W-1:0]      cand;
  logic [VID_W-1:0]      free_v, target;

`ifdef VOICE_STEAL_EN
  logic [VID_W-1:0] old_v;
  logic [AGE_W-1:0] old_age;

  // Strictly-greater scan keeps the lowest index on equal ages.
  always_comb begin
    old_v   = '0;
    old_age = age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > old_age) begin
        old_v   = VID_W'(v);
        old_age = age[v];
      end
    end
  end
`endif

  always_comb begin
    // armed is low on the first edge after reset so keys held through reset
    // never look like presses.
    press = bus.keys & ~keys_q & {NUM_KEYS{armed}};
    rel   = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      rel[v] = active[v] & ~bus.keys[vkey[v]];
    stall = |rel;

    have_cand = 1'b0;
    cand      = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending[k] && bus.keys[k]) begin
        have_cand = 1'b1;
        cand      = KEY_W'(k);
      end
    end

    have_free = 1'b0;
    free_v    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        have_free = 1'b1;
        free_v    = VID_W'(v);
      end
    end

    alloc    = 1'b0;
    target   = free_v;
    steal_nx = 1'b0;
    drop_nx  = 1'b0;
    if (have_cand && !stall) begin
      if (have_free) begin
        alloc = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        alloc    = 1'b1;
        target   = old_v;
        steal_nx = 1'b1;
`else
        drop_nx  = 1'b1;
`endif
      end
    end

    pending_nx = (pending | press) & bus.keys;
    if (have_cand && !stall)
      pending_nx[cand] = 1'b0;

    active_nx = active & ~rel;
    start_nx  = '0;
    if (alloc) begin
      active_nx[target] = 1'b1;
      start_nx[target]  = 1'b1;
    end

    count_nx = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      count_nx = count_nx + CNT_W'(active_nx[v]);
  end

  // Decision stage: all state and outputs register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q  <= '0;
      armed   <= 1'b0;
      pending <= '0;
      active  <= '0;
      start   <= '0;
      steal_r <= 1'b0;
      drop_r  <= 1'b0;
      count   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey[v] <= '0;
        age[v]  <= '0;
      end
    end else begin
      keys_q  <= bus.keys;
      armed   <= 1'b1;
      pending <= pending_nx;
      active  <= active_nx;
      start   <= start_nx;
      steal_r <= steal_nx;
      drop_r  <= drop_nx;
      count   <= count_nx;
      if (alloc) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (VID_W'(v) == target) begin
            vkey[v] <= cand;
            age[v]  <= '0;
          end else if (active[v] && age[v] != AGE_MAX) begin
            age[v]  <= age[v] + AGE_W'(1);
          end
        end
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_key_out
    assign bus.voice_key[v*KEY_W +: KEY_W] = vkey[v];
  end

  assign bus.voice_active = active;
  assign bus.voice_start  = start;
  assign bus.steal        = steal_r;
  assign bus.drop         = drop_r;
  assign bus.active_count = count;
endmodule
